// File: rtl/charlie_pkg.sv
// Shared types and constants for the charlieplex scan sequencer.
package charlie_pkg;

  localparam int unsigned LED_INDEX_W       = 6;
  localparam int unsigned FRAME_W           = 64;
  localparam int unsigned LED_COUNT_DEFAULT = 56;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSeek,
    StShow,
    StBlank
  } scan_state_e;

endpackage

// File: rtl/scan_slot_timer.sv
// Per-LED slot timing: SHOW slot counter with PWM window and post-SHOW blanking counter.
module scan_slot_timer #(
  parameter int unsigned DWELL_W      = 8,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_show,
  input  logic               in_blank,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [DWELL_W-1:0] bright,
  output logic               pwm_on,
  output logic               show_done,
  output logic               blank_done
);

  localparam logic [3:0] BlankLast =
    (BLANK_CYCLES == 0) ? 4'd0 : 4'(BLANK_CYCLES - 1);
  localparam logic [DWELL_W:0] SlotOne = {{DWELL_W{1'b0}}, 1'b1};

  logic [DWELL_W-1:0] slot_cnt_q;
  logic [3:0]         blank_cnt_q;
  logic [DWELL_W:0]   slot_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      blank_cnt_q <= '0;
    end else begin
      if (start) begin
        slot_cnt_q <= '0;
      end else if (in_show) begin
        slot_cnt_q <= slot_cnt_q + {{(DWELL_W-1){1'b0}}, 1'b1};
      end
      if (in_show) begin
        blank_cnt_q <= '0;
      end else if (in_blank) begin
        blank_cnt_q <= blank_cnt_q + 4'd1;
      end
    end
  end

  // Look-ahead: PWM state of the slot cycle that follows the coming edge, so the
  // registered led_on lines up with the SHOW cycle it belongs to.
  always_comb begin
    slot_next  = start ? '0 : ({1'b0, slot_cnt_q} + SlotOne);
    pwm_on     = slot_next < {1'b0, bright};
    show_done  = in_show && (slot_cnt_q == dwell);
    blank_done = in_blank && (blank_cnt_q == BlankLast);
  end

endmodule

// File: rtl/charlie_scan_ctrl.sv
// Charlieplex scan sequencer: snapshots the frame at each boundary and walks it LED by LED.
module charlie_scan_ctrl
  import charlie_pkg::*;
#(
  parameter int unsigned LED_COUNT    = LED_COUNT_DEFAULT,
  parameter int unsigned DWELL_W      = 8,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FRAME_W-1:0]     frame_in,
  input  logic                   cfg_enable,
  input  logic                   cfg_skip,
  input  logic [DWELL_W-1:0]     cfg_dwell,
  input  logic [DWELL_W-1:0]     cfg_bright,
  output logic [LED_INDEX_W-1:0] charlie_index,
  output logic                   led_on,
  output logic                   frame_start,
  output logic [7:0]             frame_count,
  output logic                   busy
);

  localparam logic [LED_INDEX_W-1:0] LastIdx = LED_INDEX_W'(LED_COUNT - 1);
  localparam logic [LED_INDEX_W-1:0] IdxOne  = LED_INDEX_W'(1);

  scan_state_e            state_q;
  logic [LED_INDEX_W-1:0] index_q;
  logic                   led_on_q;
  logic                   frame_start_q;
  logic [7:0]             frame_count_q;
  logic [FRAME_W-1:0]     frame_sh_q;
  logic [DWELL_W-1:0]     dwell_sh_q;
  logic [DWELL_W-1:0]     bright_sh_q;
  logic                   skip_sh_q;

  logic start, in_show, in_blank;
  logic pwm_on, show_done, blank_done;
  logic last_led, advance, enter_load, lit_next;

  scan_slot_timer #(
    .DWELL_W      (DWELL_W),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_show    (in_show),
    .in_blank   (in_blank),
    .dwell      (dwell_sh_q),
    .bright     (bright_sh_q),
    .pwm_on     (pwm_on),
    .show_done  (show_done),
    .blank_done (blank_done)
  );

  always_comb begin
    in_show    = (state_q == StShow);
    in_blank   = (state_q == StBlank);
    start      = (state_q == StSeek) && (!skip_sh_q || frame_sh_q[index_q]);
    last_led   = (index_q == LastIdx);
    // Leaving the current LED: after blanking, or straight from SHOW when there is no gap.
    advance    = blank_done || ((BLANK_CYCLES == 0) && show_done);
    enter_load = (state_q == StIdle) ||
                 (last_led && (((state_q == StSeek) && !start) || advance));
    lit_next   = frame_sh_q[index_q] && pwm_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      index_q       <= '0;
      led_on_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      frame_sh_q    <= '0;
      dwell_sh_q    <= '0;
      bright_sh_q   <= '0;
      skip_sh_q     <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      led_on_q      <= 1'b0;
      if (!cfg_enable) begin
        state_q <= StIdle;
        index_q <= '0;
      end else if (enter_load) begin
        state_q       <= StLoad;
        index_q       <= '0;
        frame_start_q <= 1'b1;
        frame_count_q <= frame_count_q + 8'd1;
      end else begin
        case (state_q)
          StLoad: begin
            frame_sh_q  <= frame_in;
            dwell_sh_q  <= cfg_dwell;
            bright_sh_q <= cfg_bright;
            skip_sh_q   <= cfg_skip;
            state_q     <= StSeek;
          end
          StSeek: begin
            if (start) begin
              state_q  <= StShow;
              led_on_q <= lit_next;
            end else begin
              index_q <= index_q + IdxOne;
            end
          end
          StShow: begin
            if (advance) begin
              state_q <= StSeek;
              index_q <= index_q + IdxOne;
            end else if (show_done) begin
              state_q <= StBlank;
            end else begin
              led_on_q <= lit_next;
            end
          end
          StBlank: begin
            if (advance) begin
              state_q <= StSeek;
              index_q <= index_q + IdxOne;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign charlie_index = index_q;
  assign led_on        = led_on_q;
  assign frame_start   = frame_start_q;
  assign frame_count   = frame_count_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_charlie_scan_ctrl.sv
// Directed bench for charlie_scan_ctrl with default parameters (56 LEDs, 8-bit dwell, 1 blank).
module tb_charlie_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] frame_in;
  logic        cfg_enable;
  logic        cfg_skip;
  logic [7:0]  cfg_dwell;
  logic [7:0]  cfg_bright;
  logic [5:0]  charlie_index;
  logic        led_on;
  logic        frame_start;
  logic [7:0]  frame_count;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int fc_exp = 0;
  int lit_per[64];
  int period;
  int total;
  int n;

  charlie_scan_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_in      (frame_in),
    .cfg_enable    (cfg_enable),
    .cfg_skip      (cfg_skip),
    .cfg_dwell     (cfg_dwell),
    .cfg_bright    (cfg_bright),
    .charlie_index (charlie_index),
    .led_on        (led_on),
    .frame_start   (frame_start),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_fc();
    fc_exp++;
    chk("frame_count", {56'd0, frame_count}, 64'(fc_exp % 256));
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin
      step();
      k++;
    end while (!frame_start && k < 2000);
    chk("wait_frame_start", {63'd0, frame_start}, 64'd1);
    chk_fc();
  endtask

  // Runs from one LOAD to the next, tallying lit cycles per index; optionally
  // rewrites frame_in/cfg_dwell at cycle chg_at of the frame.
  task automatic run_frame(input int chg_at, input logic [63:0] nf, input logic [7:0] nd,
                           output int per, output int tot);
    for (int i = 0; i < 64; i++) lit_per[i] = 0;
    per = 0;
    tot = 0;
    do begin
      step();
      per++;
      if (led_on) begin
        lit_per[charlie_index]++;
        tot++;
      end
      if (per == chg_at) begin
        frame_in  = nf;
        cfg_dwell = nd;
      end
    end while (!frame_start && per < 4000);
    chk("run_frame_end", {63'd0, frame_start}, 64'd1);
    chk_fc();
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_enable = 1'b0;
    cfg_skip   = 1'b0;
    cfg_dwell  = 8'd3;
    cfg_bright = 8'd255;
    frame_in   = '1;

    // Reset state
    step();
    chk("rst_index", {58'd0, charlie_index}, 64'd0);
    chk("rst_led_on", {63'd0, led_on}, 64'd0);
    chk("rst_frame_start", {63'd0, frame_start}, 64'd0);
    chk("rst_frame_count", {56'd0, frame_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Enable latency: LOAD, SEEK, SHOW after successive edges
    cfg_enable = 1'b1;
    step();
    chk("load_frame_start", {63'd0, frame_start}, 64'd1);
    chk("load_busy", {63'd0, busy}, 64'd1);
    chk_fc();
    step();
    chk("seek_frame_start", {63'd0, frame_start}, 64'd0);
    chk("seek_led_on", {63'd0, led_on}, 64'd0);
    step();
    chk("first_show_led_on", {63'd0, led_on}, 64'd1);
    chk("first_show_index", {58'd0, charlie_index}, 64'd0);

    // Full scan: 4 lit SHOW cycles, 1 BLANK, 1 SEEK per LED, wrap to LOAD
    for (int i = 0; i < 56; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk("scan_show_led_on", {63'd0, led_on}, 64'd1);
        chk("scan_show_index", {58'd0, charlie_index}, 64'(i));
        step();
      end
      chk("scan_blank_led_on", {63'd0, led_on}, 64'd0);
      chk("scan_blank_index", {58'd0, charlie_index}, 64'(i));
      step();
      if (i < 55) begin
        chk("scan_seek_index", {58'd0, charlie_index}, 64'(i + 1));
        chk("scan_seek_led_on", {63'd0, led_on}, 64'd0);
        step();
      end else begin
        chk("scan_wrap_frame_start", {63'd0, frame_start}, 64'd1);
        chk("scan_wrap_index", {58'd0, charlie_index}, 64'd0);
        chk_fc();
      end
    end
    run_frame(-1, '0, 8'd0, period, total);
    chk("full_period", 64'(period), 64'd337);
    chk("full_lit", 64'(total), 64'd224);

    // PWM window at index 5
    cfg_dwell  = 8'd7;
    cfg_bright = 8'd3;
    frame_in   = 64'd1 << 5;
    wait_fs();
    run_frame(-1, '0, 8'd0, period, total);
    chk("pwm_period", 64'(period), 64'd561);
    chk("pwm_lit_idx5", 64'(lit_per[5]), 64'd3);
    chk("pwm_lit_total", 64'(total), 64'd3);
    cfg_bright = 8'd0;
    wait_fs();
    run_frame(-1, '0, 8'd0, period, total);
    chk("bright0_lit_total", 64'(total), 64'd0);

    // Skip dark LEDs
    cfg_skip   = 1'b1;
    cfg_dwell  = 8'd3;
    cfg_bright = 8'd255;
    frame_in   = (64'd1 << 2) | (64'd1 << 40);
    wait_fs();
    run_frame(-1, '0, 8'd0, period, total);
    chk("skip_period", 64'(period), 64'd67);
    chk("skip_lit_idx2", 64'(lit_per[2]), 64'd4);
    chk("skip_lit_idx40", 64'(lit_per[40]), 64'd4);
    chk("skip_lit_total", 64'(total), 64'd8);
    frame_in = '0;
    wait_fs();
    run_frame(-1, '0, 8'd0, period, total);
    chk("dark_period", 64'(period), 64'd57);
    chk("dark_lit_total", 64'(total), 64'd0);

    // Snapshot: mid-frame changes only take effect at the next frame
    cfg_skip = 1'b0;
    frame_in = '1;
    wait_fs();
    run_frame(20, '0, 8'd7, period, total);
    chk("snap_cur_period", 64'(period), 64'd337);
    chk("snap_cur_lit", 64'(total), 64'd224);
    run_frame(-1, '0, 8'd0, period, total);
    chk("snap_next_period", 64'(period), 64'd561);
    chk("snap_next_lit", 64'(total), 64'd0);

    // Disable while lit
    frame_in  = '1;
    cfg_dwell = 8'd3;
    wait_fs();
    n = 0;
    do begin
      step();
      n++;
    end while (!(led_on && charlie_index == 6'd3) && n < 500);
    chk("dis_reach_show", {63'd0, led_on}, 64'd1);
    cfg_enable = 1'b0;
    step();
    chk("dis_led_on", {63'd0, led_on}, 64'd0);
    chk("dis_index", {58'd0, charlie_index}, 64'd0);
    chk("dis_busy", {63'd0, busy}, 64'd0);
    chk("dis_frame_count", {56'd0, frame_count}, 64'(fc_exp % 256));
    step();
    step();
    chk("dis_hold_frame_count", {56'd0, frame_count}, 64'(fc_exp % 256));
    cfg_enable = 1'b1;
    step();
    chk("reen_frame_start", {63'd0, frame_start}, 64'd1);
    chk_fc();

    // Asynchronous reset while lit
    n = 0;
    do begin
      step();
      n++;
    end while (!(led_on && charlie_index == 6'd2) && n < 500);
    chk("rst_reach_show", {63'd0, led_on}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led_on", {63'd0, led_on}, 64'd0);
    chk("arst_index", {58'd0, charlie_index}, 64'd0);
    chk("arst_frame_count", {56'd0, frame_count}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/charlie_scan_ctrl.md
Name: charlie_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the charlieplex driver.
- Replaces the raw free-running counter bits as the source of charlie_index.
- Walks the 64-bit frame buffer LED by LED, taking a tear-free snapshot at each frame boundary. Each LED gets a programmable dwell, a PWM brightness window and a blanking gap against ghosting.
- Optionally skips dark LEDs, so lit LEDs receive a larger share of the frame time.

Parameters:
- LED_COUNT, 56, number of scanned slots (indices 0..LED_COUNT-1); range 1..64; indices at or above LED_COUNT are never emitted.
- DWELL_W, 8, width of cfg_dwell and cfg_bright.
- BLANK_CYCLES, 1, dead cycles after each SHOW; range 0..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_in  in  64  frame buffer; bit n is LED n
- cfg_enable  in  1  scan enable, sampled every cycle
- cfg_skip  in  1  1 = skip dark LEDs
- cfg_dwell  in  DWELL_W  SHOW length minus 1
- cfg_bright  in  DWELL_W  number of lit cycles per SHOW
- charlie_index  out  6  LED index to the driver
- led_on  out  1  driver drive-enable; 0 means all pins hi-Z
- frame_start  out  1  one-cycle pulse in LOAD
- frame_count  out  8  frames started, wraps 255→0
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-low reset rst_n.
- Reset values:
  - state = IDLE
  - charlie_index = 0, led_on = 0, frame_start = 0, frame_count = 0, busy = 0
  - shadow registers = 0
  - Reset is honoured mid-operation; led_on drops immediately and asynchronously.
- All outputs are registered except busy, which is decoded from state.
- FSM states: IDLE, LOAD, SEEK, SHOW, BLANK.
- IDLE:
  - led_on = 0, index = 0.
  - cfg_enable = 1 → LOAD.
- LOAD (1 cycle):
  - frame_shadow ← frame_in; dwell_sh ← cfg_dwell; bright_sh ← cfg_bright; skip_sh ← cfg_skip.
  - index ← 0; frame_start = 1; frame_count += 1.
  - → SEEK.
  - Configuration and frame data are only ever taken in LOAD; mid-frame changes never affect the current frame.
- SEEK (≥1 cycle per LED visited):
  - If !skip_sh or frame_shadow[index] → SHOW, with slot_cnt ← 0.
  - Else if index == LED_COUNT-1 → LOAD.
  - Else index += 1, remain in SEEK.
  - An all-dark frame with skip set costs LOAD + LED_COUNT cycles. Frame boundaries therefore keep occurring.
- SHOW (dwell_sh+1 cycles):
  - led_on = frame_shadow[index] AND (slot_cnt < bright_sh).
  - bright_sh = 0 → always dark; bright_sh > dwell_sh → lit for the full slot.
  - At slot_cnt == dwell_sh → BLANK, or go straight to advance when BLANK_CYCLES = 0.
- BLANK (BLANK_CYCLES cycles):
  - led_on = 0; charlie_index is held.
- Advance:
  - If index == LED_COUNT-1 → LOAD.
  - Else index += 1 → SEEK.
- led_on is registered and changes in the same cycle as the state it belongs to. charlie_index never changes in a cycle where led_on = 1.
- cfg_enable = 0:
  - In any state, the next state is IDLE, with led_on = 0 and index = 0 on the following edge.
  - This takes priority over every other transition.
  - frame_count is retained.
- Enable latency: with cfg_enable rising at edge k, the machine is in LOAD after edge k, SEEK after k+1 and SHOW after k+2.
- Frame period with skip = 0: 1 + LED_COUNT × (1 + dwell+1 + BLANK_CYCLES).
- Counters are unsigned: slot_cnt is DWELL_W bits wide, the blank counter 4 bits.

Decomposition:
- Shared package charlie_pkg holds:
  - the state enum (IDLE, LOAD, SEEK, SHOW, BLANK)
  - LED_INDEX_W = 6
  - FRAME_W = 64
  - the default LED_COUNT
- One sub-module, scan_slot_timer, owns slot_cnt and the blank counter. It takes start, dwell and bright as inputs and outputs pwm_on, show_done and blank_done.
- The FSM, index and shadow registers stay in the top of the block.

Test Plan:
1. Reset/enable: hold rst_n = 0 → all outputs 0. Release rst_n, then set enable = 1 at edge k → frame_start high exactly in the cycle after k, frame_count = 1, first SHOW two cycles later.
2. Full scan timing (LED_COUNT = 56, dwell = 3, blank = 1, bright = 255, skip = 0, frame_in = all ones) → frame_start period 337 cycles. charlie_index steps 0..55 then 0. led_on high 4 cycles per LED, then 2 cycles low.
3. PWM: dwell = 7, bright = 3, frame_in = 1<<5 → at index 5 led_on is high for exactly 3 of 8 SHOW cycles. All other indices show led_on = 0. bright = 0 → no led_on at all.
4. Skip: skip = 1, frame_in = (1<<2)|(1<<40) → only indices 2 and 40 enter SHOW. Frame period = 1 + 56 + 2 × (4 + 1). All-dark frame → period 57, led_on never high.
5. Snapshot: change frame_in and cfg_dwell mid-frame → current frame unchanged. New values visible from the next frame_start onward.
6. Disable/reset mid-SHOW: enable = 0 while led_on = 1 → led_on = 0 and index = 0 after one edge, frame_count held. Asserting rst_n mid-SHOW → led_on = 0 immediately, without waiting for a clock edge.
